// File: rtl/surf4_sst_clk_seq.sv
// surf4_sst_clk_seq: MMCM input-clock sequencer for the SURF4 SST clock.
// Settles the local oscillator, pulses MMCM reset, retries, falls back, powers down.
module surf4_sst_clk_seq #(
  parameter int RST_CYCLES   = 16,
  parameter int OSC_SETTLE   = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       sel_i,
  input  logic       fallback_en_i,
  input  logic       relock_en_i,
  input  logic       pwrdn_i,
  input  logic       mmcm_locked_i,
  input  logic       mmcm_clkinstopped_i,
  output logic       mmcm_rst_o,
  output logic       mmcm_pwrdwn_o,
  output logic       mmcm_clksel_o,
  output logic       local_osc_en_o,
  output logic       locked_o,
  output logic       busy_o,
  output logic       fail_o,
  output logic       irq_o,
  output logic [2:0] state_o,
  output logic [1:0] retry_o,
  output logic       sel_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_OSC_WAIT  = 3'd1,
    S_RESET     = 3'd2,
    S_WAIT_LOCK = 3'd3,
    S_LOCKED    = 3'd4,
    S_FAIL      = 3'd5,
    S_PWRDN     = 3'd6
  } state_t;

  localparam int CM1  = (OSC_SETTLE > RST_CYCLES) ? OSC_SETTLE : RST_CYCLES;
  localparam int CMAX = (LOCK_TIMEOUT > CM1) ? LOCK_TIMEOUT : CM1;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] OSC_LAST = CW'(OSC_SETTLE - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_SAT  = '1;
  localparam logic [1:0]    MAXR     = 2'(MAX_RETRY);

  logic r_lock_s1, r_lock_s2;
  logic r_stop_s1, r_stop_s2;

  state_t        r_state, w_state;
  logic          r_sel, w_sel;
  logic [1:0]    r_retry, w_retry, w_retry_inc;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_osc, w_osc;
  logic          r_clksel, w_clksel;
  logic          w_irq, w_go, w_loss;

  logic r_mmcm_rst, r_pwrdwn, r_locked;
  logic r_busy, r_fail, r_irq;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_lock_s1 <= 1'b0;
      r_lock_s2 <= 1'b0;
      r_stop_s1 <= 1'b0;
      r_stop_s2 <= 1'b0;
    end else begin
      r_lock_s1 <= mmcm_locked_i;
      r_lock_s2 <= r_lock_s1;
      r_stop_s1 <= mmcm_clkinstopped_i;
      r_stop_s2 <= r_stop_s1;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_sel    = r_sel;
    w_retry  = r_retry;
    w_osc    = r_osc;
    w_clksel = r_clksel;
    w_irq    = 1'b0;
    w_go     = 1'b0;
    w_cnt    = (r_cnt == CNT_SAT) ? r_cnt : r_cnt + CW'(1);
    w_retry_inc = (r_retry == 2'd3) ? r_retry : r_retry + 2'd1;
    w_loss   = !r_lock_s2 || r_stop_s2;

    if (pwrdn_i) begin
      w_state = S_PWRDN;
    end else begin
      unique case (r_state)
        S_IDLE, S_FAIL: w_go = start_i;
        S_OSC_WAIT: begin
          if (r_cnt == OSC_LAST) w_state = S_RESET;
        end
        S_RESET: begin
          if (r_cnt == RST_LAST) w_state = S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (r_lock_s2) begin
            w_state = S_LOCKED;
          end else if (r_cnt == TMO_LAST) begin
            if (w_retry_inc < MAXR) begin
              w_retry = w_retry_inc;
              w_state = S_RESET;
            end else if (!r_sel && fallback_en_i) begin
              w_sel   = 1'b1;
              w_retry = 2'd0;
              w_state = S_OSC_WAIT;
            end else begin
              w_retry = w_retry_inc;
              w_state = S_FAIL;
            end
          end
        end
        S_LOCKED: begin
          if (start_i) begin
            w_go = 1'b1;
          end else if (w_loss) begin
            w_irq = 1'b1;
            if (relock_en_i) begin
              w_retry = 2'd0;
              w_state = S_RESET;
            end else begin
              w_state = S_FAIL;
            end
          end
        end
        S_PWRDN: begin
          w_retry = 2'd0;
          w_state = S_RESET;
        end
        default: w_state = S_IDLE;
      endcase
    end

    if (w_go) begin
      w_sel   = sel_i;
      w_retry = 2'd0;
      w_state = (sel_i && !r_osc) ? S_OSC_WAIT : S_RESET;
    end

    // entry actions: clksel and oscillator enable only move on state entry
    if (w_state != r_state) begin
      w_cnt = '0;
      if (w_state == S_LOCKED || w_state == S_FAIL) w_irq = 1'b1;
      if (w_state == S_OSC_WAIT) w_osc = 1'b1;
      if (w_state == S_RESET) begin
        w_clksel = !w_sel;
        if (!w_sel) w_osc = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= S_IDLE;
      r_sel      <= 1'b0;
      r_retry    <= 2'd0;
      r_cnt      <= '0;
      r_osc      <= 1'b0;
      r_clksel   <= 1'b1;
      r_mmcm_rst <= 1'b1;
      r_pwrdwn   <= 1'b0;
      r_locked   <= 1'b0;
      r_busy     <= 1'b0;
      r_fail     <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sel      <= w_sel;
      r_retry    <= w_retry;
      r_cnt      <= w_cnt;
      r_osc      <= w_osc;
      r_clksel   <= w_clksel;
      r_mmcm_rst <= !(w_state == S_WAIT_LOCK || w_state == S_LOCKED);
      r_pwrdwn   <= (w_state == S_PWRDN);
      r_locked   <= (w_state == S_LOCKED);
      r_busy     <= (w_state == S_OSC_WAIT) || (w_state == S_RESET) ||
                    (w_state == S_WAIT_LOCK);
      r_fail     <= (w_state == S_FAIL);
      r_irq      <= w_irq;
    end
  end

  assign mmcm_rst_o     = r_mmcm_rst;
  assign mmcm_pwrdwn_o  = r_pwrdwn;
  assign mmcm_clksel_o  = r_clksel;
  assign local_osc_en_o = r_osc;
  assign locked_o       = r_locked;
  assign busy_o         = r_busy;
  assign fail_o         = r_fail;
  assign irq_o          = r_irq;
  assign state_o        = r_state;
  assign retry_o        = r_retry;
  assign sel_o          = r_sel;

endmodule
